// File: rtl/button_debounce_pulser.sv
// button_debounce_pulser
//   Turns one raw active-low push-button into a clean debounced level and a
//   single-cycle pulse. The pulse drives the step enable of the downstream
//   register stage, so it produces one register step per physical press.
//   Contact bounce cannot cause extra steps.
//
// Ports
//   clk       system clock; the only clock in the block
//   reset     asynchronous, active-high; clears all state immediately
//   button_n  raw pad input, active-low (0 = pressed), asynchronous to clk
//   pulse     registered, high for exactly one clk cycle per accepted press
//   level     registered debounced button state, active-high (1 = pressed)
//
// Configuration
//   AUTO_REPEAT_EN  when defined, holding the button makes the block emit
//                   extra pulses. The first comes REPEAT_DELAY cycles after
//                   the press pulse. After that, one comes every
//                   REPEAT_PERIOD cycles for as long as the button is held.
//                   When undefined, no repeat logic is built.

module button_debounce_pulser #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic pulse,
  output logic level
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 1) &&
                             (REPEAT_PERIOD >= 1) &&
                             (CNT_W >= $clog2(DEBOUNCE_CYCLES + 1));

  if (!PARAMS_OK) begin : g_bad_params
    $error("button_debounce_pulser: illegal parameter combination");
  end

  logic [1:0]       sync;
  logic             pressed_s;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pulse_next, level_next;

  // Two-flop synchronizer. Both flops reset to "released" so that a button
  // held through reset is still seen as a fresh press afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], button_n};
    end
  end

  assign pressed_s = ~sync[1];

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_next;
  logic             rep_phase, rep_phase_next;

  // The repeat counter only runs while the FSM stays in HELD. Any exit from
  // HELD clears it, so returning from RELEASE_WAIT starts the long delay again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_next;
      rep_phase <= rep_phase_next;
    end
  end
`endif

  // State register. pulse and level are registered copies of the next-state
  // decode, so there is no combinational path from the pad to the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
      level <= level_next;
    end
  end

  // cnt holds how many consecutive samples agreed before the current one.
  // A change is accepted on the DEBOUNCE_CYCLES-th agreeing sample. The
  // ">=" lets DEBOUNCE_CYCLES == 1 accept on the very first wait cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (pressed_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
    endcase

    level_next = (state_next == HELD) || (state_next == RELEASE_WAIT);

`ifdef AUTO_REPEAT_EN
    rep_cnt_next   = '0;
    rep_phase_next = 1'b0;
    if ((state == HELD) && (state_next == HELD)) begin
      if (!rep_phase) begin
        if (rep_cnt == REP_DELAY_LAST) begin
          pulse_next     = 1'b1;
          rep_phase_next = 1'b1;
        end else begin
          rep_cnt_next = rep_cnt + REP_ONE;
        end
      end else begin
        rep_phase_next = 1'b1;
        if (rep_cnt == REP_PERIOD_LAST) begin
          pulse_next = 1'b1;
        end else begin
          rep_cnt_next = rep_cnt + REP_ONE;
        end
      end
    end
`endif
  end

endmodule
